// File: rtl/alu_issue_if.sv
// Handshake bundle for the decode/issue stage: upstream instruction port and
// downstream ALU issue port, plus the pipeline flush.
interface alu_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [31:0] alu_src0;
  logic [31:0] alu_src1;
  logic [4:0]  rd;
  logic        rf_we;
  logic        illegal;

  modport master (
    output flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_op, alu_src0, alu_src1, rd, rf_we, illegal
  );

  modport slave (
    input  flush, in_valid, inst, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_op, alu_src0, alu_src1, rd, rf_we, illegal
  );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: decodes one instruction into ALU operation,
// operands and writeback control, held in a single valid/ready output slot.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus
);
  localparam int unsigned OpW   = 5;
  localparam int unsigned DataW = 32;

  localparam logic [OpW-1:0] OP_ADD  = 5'd0;
  localparam logic [OpW-1:0] OP_SUB  = 5'd1;
  localparam logic [OpW-1:0] OP_SLT  = 5'd2;
  localparam logic [OpW-1:0] OP_SLTU = 5'd3;
  localparam logic [OpW-1:0] OP_AND  = 5'd4;
  localparam logic [OpW-1:0] OP_OR   = 5'd5;
  localparam logic [OpW-1:0] OP_XOR  = 5'd6;
  localparam logic [OpW-1:0] OP_SLL  = 5'd7;
  localparam logic [OpW-1:0] OP_SRL  = 5'd8;
  localparam logic [OpW-1:0] OP_SRA  = 5'd9;
  localparam logic [OpW-1:0] OP_SRC0 = 5'd10;
  localparam logic [OpW-1:0] OP_SRC1 = 5'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // funct3 to ALU op; alt selects SUB/SRA in the 000/101 slots
  function automatic logic [OpW-1:0] f3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [DataW-1:0] imm_i, imm_s, imm_u;
  logic [OpW-1:0]   dec_op;
  logic [DataW-1:0] dec_src0, dec_src1;
  logic [4:0]       dec_rd;
  logic             dec_we, dec_ill;

  // Combinational decode of the offered instruction
  always_comb begin
    opcode   = bus.inst[6:0];
    funct3   = bus.inst[14:12];
    funct7   = bus.inst[31:25];
    imm_i    = {{20{bus.inst[31]}}, bus.inst[31:20]};
    imm_s    = {{20{bus.inst[31]}}, bus.inst[31:25], bus.inst[11:7]};
    imm_u    = {bus.inst[31:12], 12'h000};
    dec_rd   = bus.inst[11:7];
    dec_op   = OP_SRC0;
    dec_src0 = '0;
    dec_src1 = '0;
    dec_we   = 1'b0;
    dec_ill  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_op   = f3_op(funct3, funct7 == 7'b0100000);
        dec_src0 = bus.rs1_data;
        dec_src1 = bus.rs2_data;
        dec_we   = 1'b1;
        dec_ill  = !((funct7 == 7'b0000000) ||
                     ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec_src0 = bus.rs1_data;
        dec_src1 = imm_i;
        dec_we   = 1'b1;
        dec_op   = f3_op(funct3, 1'b0);
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          dec_op   = f3_op(funct3, (funct3 == 3'b101) && bus.inst[30]);
          dec_src1 = {27'h0, bus.inst[24:20]};
          dec_ill  = !((funct7 == 7'b0000000) || (funct7 == 7'b0100000));
        end
      end
      OPC_LUI: begin
        dec_op   = OP_SRC1;
        dec_src1 = imm_u;
        dec_we   = 1'b1;
      end
      OPC_AUIPC: begin
        dec_op   = OP_ADD;
        dec_src0 = bus.pc;
        dec_src1 = imm_u;
        dec_we   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        dec_op   = OP_ADD;
        dec_src0 = bus.pc;
        dec_src1 = 32'd4;
        dec_we   = 1'b1;
      end
      OPC_LOAD: begin
        dec_op   = OP_ADD;
        dec_src0 = bus.rs1_data;
        dec_src1 = imm_i;
        dec_we   = 1'b1;
      end
      OPC_STORE: begin
        dec_op   = OP_ADD;
        dec_src0 = bus.rs1_data;
        dec_src1 = imm_s;
      end
      OPC_BRANCH: begin
        dec_op   = OP_SUB;
        dec_src0 = bus.rs1_data;
        dec_src1 = bus.rs2_data;
      end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill || (dec_rd == 5'd0)) dec_we = 1'b0;
  end

  logic             valid_q, valid_d;
  logic [OpW-1:0]   op_q, op_d;
  logic [DataW-1:0] src0_q, src0_d, src1_q, src1_d;
  logic [4:0]       rd_q, rd_d;
  logic             we_q, we_d, ill_q, ill_d;
  logic             accept;

  // in_ready is combinational by definition of the handshake
  assign bus.in_ready = rst || !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Output slot update: reset > flush > load > drain
  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    src0_d  = src0_q;
    src1_d  = src1_q;
    rd_d    = rd_q;
    we_d    = we_q;
    ill_d   = ill_q;
    if (rst) begin
      valid_d = 1'b0;
      op_d    = OP_ADD;
      src0_d  = '0;
      src1_d  = '0;
      rd_d    = '0;
      we_d    = 1'b0;
      ill_d   = 1'b0;
    end else if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      op_d    = dec_op;
      src0_d  = dec_src0;
      src1_d  = dec_src1;
      rd_d    = dec_rd;
      we_d    = dec_we;
      ill_d   = dec_ill;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    op_q    <= op_d;
    src0_q  <= src0_d;
    src1_q  <= src1_d;
    rd_q    <= rd_d;
    we_q    <= we_d;
    ill_q   <= ill_d;
  end

  assign bus.out_valid = valid_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_src0  = src0_q;
  assign bus.alu_src1  = src1_q;
  assign bus.rd        = rd_q;
  assign bus.rf_we     = we_q;
  assign bus.illegal   = ill_q;
endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: decode vector table plus stall, flush and
// reset-during-stall sequences.
module tb_alu_issue;
  localparam logic [4:0] ADD  = 5'd0;
  localparam logic [4:0] SUB  = 5'd1;
  localparam logic [4:0] SLTU = 5'd3;
  localparam logic [4:0] XOR  = 5'd6;
  localparam logic [4:0] SRA  = 5'd9;
  localparam logic [4:0] SRC0 = 5'd10;
  localparam logic [4:0] SRC1 = 5'd11;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  op;
    logic [31:0] s0;
    logic [31:0] s1;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
    logic        chk_data;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_issue_if bus ();

  alu_issue u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [75:0] out_word();
    return {bus.alu_op, bus.alu_src0, bus.alu_src1, bus.rd, bus.rf_we, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid = 1'b1;
    bus.inst     = v.inst;
    bus.pc       = v.pc;
    bus.rs1_data = v.rs1;
    bus.rs2_data = v.rs2;
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check({name, " out_valid"}, 76'(bus.out_valid), 76'(1'b1));
    if (v.chk_data)
      check({name, " fields"}, out_word(), {v.op, v.s0, v.s1, v.rd, v.we, v.ill});
    else
      check({name, " we/ill"}, 76'({bus.rf_we, bus.illegal}), 76'({v.we, v.ill}));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " out_valid"}, 76'(bus.out_valid), 76'(1'b0));
    check({name, " fields"}, out_word(), {ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0});
  endtask

  initial begin
    //          inst          pc        rs1           rs2       op    src0          src1          rd  we ill chk
    vecs[0]  = '{32'h002081B3, 32'h0,   32'd5,        32'd7,    ADD,  32'd5,        32'd7,        5'd3, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{32'h40435293, 32'h0,   32'h80000000, 32'h0,    SRA,  32'h80000000, 32'd4,        5'd5, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'hFFF00013, 32'h0,   32'h10,       32'h0,    ADD,  32'h10,       32'hFFFFFFFF, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{32'h12345097, 32'h100, 32'h0,        32'h0,    ADD,  32'h100,      32'h12345000, 5'd1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{32'h000000EF, 32'h200, 32'h0,        32'h0,    ADD,  32'h200,      32'd4,        5'd1, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{32'hABCDE137, 32'h0,   32'h55,       32'h66,   SRC1, 32'h0,        32'hABCDE000, 5'd2, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{32'h40208233, 32'h0,   32'd10,       32'd3,    SUB,  32'd10,       32'd3,        5'd4, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{32'hFFC3A303, 32'h0,   32'h1000,     32'h0,    ADD,  32'h1000,     32'hFFFFFFFC, 5'd6, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'h0020A423, 32'h0,   32'h40,       32'h99,   ADD,  32'h40,       32'd8,        5'd8, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h00208063, 32'h0,   32'd9,        32'd9,    SUB,  32'd9,        32'd9,        5'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{32'h000002FF, 32'h44,  32'h12,       32'h34,   SRC0, 32'h0,        32'h0,        5'd5, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{32'h022081B3, 32'h0,   32'd5,        32'd7,    ADD,  32'd5,        32'd7,        5'd3, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{32'h00513093, 32'h0,   32'd7,        32'h0,    SLTU, 32'd7,        32'd5,        5'd1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{32'h02009093, 32'h0,   32'd1,        32'h0,    ADD,  32'h0,        32'h0,        5'd1, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{32'h009443B3, 32'h0,   32'hF0F0,     32'h0FF0, XOR,  32'hF0F0,     32'h0FF0,     5'd7, 1'b1, 1'b0, 1'b1};
    vecs[15] = '{32'h000280E7, 32'h300, 32'h0,        32'h0,    ADD,  32'h300,      32'd4,        5'd1, 1'b1, 1'b0, 1'b1};
    vecs[16] = '{32'h4020F1B3, 32'h0,   32'd1,        32'd2,    ADD,  32'h0,        32'h0,        5'd3, 1'b0, 1'b1, 1'b0};

    // Reset with a live input offered: it must be ignored
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(vecs[0]);
    @(negedge clk);
    check("in_ready during rst", 76'(bus.in_ready), 76'(1'b1));
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("idle out_valid", 76'(bus.out_valid), 76'(1'b0));

    // Back-to-back decode table with out_ready high
    for (int i = 0; i <= NV; i++) begin
      if (i > 0) check_vec($sformatf("vec%0d", i - 1), vecs[i - 1]);
      if (i < NV) begin
        check($sformatf("vec%0d in_ready", i), 76'(bus.in_ready), 76'(1'b1));
        drive(vecs[i]);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("drain out_valid", 76'(bus.out_valid), 76'(1'b0));

    // Stall: hold A while B is offered, then release
    bus.out_ready = 1'b0;
    drive(vecs[0]);
    @(negedge clk);
    drive(vecs[3]);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("stall%0d in_ready", k), 76'(bus.in_ready), 76'(1'b0));
      check_vec($sformatf("stall%0d held", k), vecs[0]);
      @(negedge clk);
    end
    check_vec("stall3 held", vecs[0]);
    bus.out_ready = 1'b1;
    #1;
    check("release in_ready", 76'(bus.in_ready), 76'(1'b1));
    @(negedge clk);
    check_vec("after release", vecs[3]);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("consume no refill", 76'(bus.out_valid), 76'(1'b0));

    // Flush with a held entry and a same-cycle handshake
    bus.out_ready = 1'b0;
    drive(vecs[4]);
    @(negedge clk);
    check_vec("flush pre-held", vecs[4]);
    drive(vecs[5]);
    bus.out_ready = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush out_valid", 76'(bus.out_valid), 76'(1'b0));
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("post-flush out_valid", 76'(bus.out_valid), 76'(1'b0));

    // Reset during a stall drops the held entry
    bus.out_ready = 1'b0;
    drive(vecs[6]);
    @(negedge clk);
    check_vec("rst pre-held", vecs[6]);
    drive(vecs[7]);
    rst = 1'b1;
    #1;
    check("rst stall in_ready", 76'(bus.in_ready), 76'(1'b1));
    @(negedge clk);
    check_reset_vals("rst mid-stall");
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("after rst out_valid", 76'(bus.out_valid), 76'(1'b0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage for the RV32I datapath: accepts a fetched instruction with its PC and register-file read data, and generates the `alu_op`, `alu_src0` and `alu_src1` values consumed by the ALU, plus writeback control. It holds one registered output entry behind a valid/ready handshake, so the downstream execute stage can stall it. It also supports a flush.

## Interface
- No parameters. Operation codes are the `logic_type.vh` macros: `ADD SUB SLT SLTU AND OR XOR SLL SRL SRA SRC0 SRC1`.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards the held entry and any same-cycle input.
- in_valid  in  1  upstream offers an instruction.
- in_ready  out  1  stage can accept this cycle.
- inst  in  32  instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register-file read of inst[19:15], valid with in_valid.
- rs2_data  in  32  register-file read of inst[24:20], valid with in_valid.
- out_valid  out  1  held entry valid.
- out_ready  in  1  execute stage consumes the entry.
- alu_op  out  5  ALU operation.
- alu_src0  out  32  ALU operand 0.
- alu_src1  out  32  ALU operand 1.
- rd  out  5  destination register.
- rf_we  out  1  write the register file at writeback.
- illegal  out  1  unsupported encoding; the entry still flows, with rf_we=0.

## Operation
- Immediates: I = sext(inst[31:20]); S = sext({inst[31:25], inst[11:7]}); B and J decoded but only pc/4 are issued; U = {inst[31:12], 12'h0}.
- OP (opcode 0110011), with funct3:
  - 000 gives ADD, or SUB when funct7=0100000.
  - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
  - 101 gives SRL, or SRA when funct7=0100000.
  - 110 OR, 111 AND.
  - src0=rs1_data, src1=rs2_data.
  - funct7 other than 0000000, or 0100000 used with funct3 other than 000/101, is illegal.
- OP-IMM (0010011): same funct3 map, src1=I-imm.
  - SUB does not exist here; funct3 000 is ADD.
  - Shifts use src1={27'h0, inst[24:20]}, with inst[30] selecting SRA.
  - Shift funct7 other than 0000000/0100000 is illegal.
- LUI (0110111): SRC1, src0=0, src1=U.
- AUIPC (0010111): ADD, src0=pc, src1=U.
- JAL (1101111) and JALR (1100111): ADD, src0=pc, src1=32'd4 (link value).
- LOAD (0000011): ADD, src0=rs1_data, src1=I, rf_we=1.
- STORE (0100011): ADD, src0=rs1_data, src1=S, rf_we=0.
- BRANCH (1100011): SUB, src0=rs1_data, src1=rs2_data, rf_we=0.
- Any other opcode: illegal=1, alu_op=SRC0, src0=src1=0, rf_we=0.
- rf_we=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR and LOAD. It is forced to 0 when rd=0 or illegal=1.
- All 32-bit arithmetic wraps; no overflow is flagged.

## Timing
- in_ready = !out_valid || out_ready (combinational; no dependence on in_valid).
- Transfer when in_valid && in_ready: the decoded fields are registered, and out_valid=1 on the next cycle. Latency is 1 cycle.
- Back-to-back: with out_ready held high, one instruction issues per cycle, with no bubbles.
- Stall: while out_valid && !out_ready, every output is held stable and in_ready=0.
- Consume without refill: out_valid falls the cycle after the consume. Data outputs keep their last value (don't-care).
- Flush has priority over everything else:
  - next cycle out_valid=0;
  - the same-cycle input is dropped, even if it was handshaken.
- Reset has priority over flush and takes effect at the next edge:
  - out_valid=0, rf_we=0, illegal=0;
  - alu_op=`ADD`, alu_src0=0, alu_src1=0, rd=0.
  - While rst=1, in_ready=1, but inputs are ignored.
- Reset mid-stall drops the held entry.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with rs1=5, rs2=7 -> one cycle later: out_valid=1, alu_op=ADD, src0=5, src1=7, rd=3, rf_we=1.
- `srai x5,x6,4` (0x40435293) with rs1=0x80000000 -> alu_op=SRA, src1=4. `addi x0,x0,-1` (0xFFF00013) -> src1=0xFFFFFFFF, rf_we=0.
- `auipc x1,0x12345` at pc=0x100 -> ADD, src0=0x100, src1=0x12345000. `jal x1` at pc=0x200 -> src0=0x200, src1=4.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs constant. Release -> held entry consumed, next instruction issues the following cycle.
- Flush asserted in the same cycle as an accepted input, while an entry is held -> out_valid=0 next cycle, both instructions lost. rst asserted during a stall -> all outputs at their reset values.
- Opcode 0x7F, and OP with funct7=0000001 -> illegal=1, rf_we=0, out_valid=1.
